// File: rtl/keystream_pkg.sv
// keystream_pkg: shared constants, tap set and FSM state type for the keystream generator.
package keystream_pkg;
   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
   localparam int TAPS [4] = '{15, 13, 12, 10};
   localparam int STEPS = 8;
   typedef enum logic {GEN, HOLD} state_t;
   function automatic logic [15:0] tap_mask();
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[TAPS[i]] = 1'b1;
      return m;
   endfunction
   localparam logic [15:0] TAP_MASK = tap_mask();
endpackage

// File: rtl/lfsr16_step.sv
// lfsr16_step: one combinational step of the 16-bit Fibonacci LFSR.
module lfsr16_step
   import keystream_pkg::*;
(
   input  logic [15:0] s_in,
   output logic [15:0] s_out,
   output logic        f
);
   assign f = ^(s_in & TAP_MASK);
   assign s_out = {s_in[14:0], f};
endmodule

// File: rtl/keystream_gen.sv
// keystream_gen: LFSR byte keystream with valid/ready output and run-time reseed.
// KEYSTREAM_PARALLEL_EN unrolls all 8 steps per cycle (one byte per cycle).
module keystream_gen
   import keystream_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic [7:0]  key,
   output logic        key_valid,
   input  logic        key_ready
);
   state_t state_q, state_d;
   logic [15:0] s_q, s_nx, seed_fix;
   logic [7:0] key_nx;
   logic step, load, accept;
   assign seed_fix = seed == '0 ? SEED_DEFAULT : seed;
   assign accept = state_q == HOLD && key_ready;
`ifdef KEYSTREAM_PARALLEL_EN
   logic [STEPS-1:0] fb;
   for (genvar i = 0; i < STEPS; i++) begin : g_step
      logic [15:0] s_i, s_o;
      logic f_o;
      if (i == 0) begin : g_first
         assign s_i = s_q;
      end else begin : g_next
         assign s_i = g_step[i-1].s_o;
      end
      lfsr16_step u_step (.s_in(s_i), .s_out(s_o), .f(f_o));
      assign fb[STEPS-1-i] = f_o;
   end
   assign s_nx = g_step[STEPS-1].s_o;
   assign key_nx = fb;
   // A held byte can be replaced in the same edge it is consumed.
   assign step = en && (state_q == GEN || key_ready);
   assign load = step;
`else
   logic [2:0] cnt_q;
   logic f;
   lfsr16_step u_step (.s_in(s_q), .s_out(s_nx), .f(f));
   assign step = state_q == GEN && en;
   assign load = step && cnt_q == 3'(STEPS - 1);
   assign key_nx = {s_q[6:0], f};
   always_ff @(posedge clk)
      cnt_q <= rst || seed_load || accept ? 3'd0 : step ? cnt_q + 3'd1 : cnt_q;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GEN;
         s_q <= SEED_DEFAULT;
         key <= 8'h00;
      end else begin
         state_q <= state_d;
         s_q <= seed_load ? seed_fix : step ? s_nx : s_q;
         key <= !seed_load && load ? key_nx : key;
      end
   end
   always_comb state_d = seed_load ? GEN : load ? HOLD : accept ? GEN : state_q;
   always_comb key_valid = state_q == HOLD;
endmodule

// File: tb/tb_keystream_gen.sv
// tb_keystream_gen: randomized scoreboard bench for keystream_gen against a bit-history model.
module tb_keystream_gen;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, seed_load = 1'b0, key_ready = 1'b0;
   logic [15:0] seed = '0;
   logic [7:0] key;
   logic key_valid;
   int n_chk = 0, n_fail = 0, n_acc = 0, c;
   logic [7:0] exp_q [$];
`ifdef KEYSTREAM_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 8;
`endif

   keystream_gen dut (.clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
                      .key(key), .key_valid(key_valid), .key_ready(key_ready));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Model: output bits extend the seed's bit history by b[n]=b[n-16]^b[n-14]^b[n-13]^b[n-11].
   task automatic reseed(input logic [15:0] sd);
      bit h [$];
      logic [15:0] s;
      logic [7:0] v;
      int n;
      s = sd == '0 ? 16'hACE1 : sd;
      exp_q.delete();
      for (int i = 15; i >= 0; i--) h.push_back(s[i]);
      for (int b = 0; b < 200; b++) begin
         v = '0;
         for (int k = 0; k < 8; k++) begin
            n = h.size();
            h.push_back(h[n-16] ^ h[n-14] ^ h[n-13] ^ h[n-11]);
            v = {v[6:0], h[n]};
         end
         exp_q.push_back(v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!key_valid && cnt < 100) begin
         cyc();
         cnt++;
      end
      if (!key_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic do_seed(input logic [15:0] sd);
      seed_load = 1'b1;
      seed = sd;
      reseed(sd);
      cyc();
      seed_load = 1'b0;
   endtask

   // Monitor: every presented byte must match the model head; pop on accept.
   always @(negedge clk) begin
      if (!rst && !seed_load && key_valid === 1'b1) begin
         if (exp_q.size() == 0) check("queue_empty", 1, 0);
         else check("key", key, exp_q[0]);
         if (key_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_acc++;
         end
      end
   end

   initial begin
      int target, guard;
      reseed(16'hACE1);
      cyc();
      cyc();
      check("rst_key", key, 8'h00);
      check("rst_valid", key_valid, 0);
      rst = 1'b0;
      wait_valid(c);
      check("first_latency", c, LAT);
      check("first_key", key, 8'hE4);
      target = n_acc + 64;
      guard = 0;
      while (n_acc < target && guard < 3000) begin
         en = ($urandom % 4) != 0;
         key_ready = $urandom % 2;
         cyc();
         guard++;
      end
      check("random_64_done", n_acc >= target, 1);
      en = 1'b1;
      key_ready = 1'b0;
      do_seed(16'h0000);
      check("seed0_valid_low", key_valid, 0);
      wait_valid(c);
      check("seed0_latency", c, LAT);
      check("seed0_key", key, 8'hE4);
      key_ready = 1'b1;
      cyc();
      key_ready = 1'b0;
      repeat (4) cyc();
      do_seed(16'($urandom));
      check("midbyte_valid_low", key_valid, 0);
      wait_valid(c);
      check("midbyte_latency", c, LAT);
      check("midbyte_key", key, exp_q[0]);
      key_ready = 1'b1;
      do_seed(16'($urandom));
      key_ready = 1'b0;
      check("accept_seed_valid_low", key_valid, 0);
      wait_valid(c);
      check("accept_seed_latency", c, LAT);
      do_seed(16'($urandom));
      en = 1'b0;
      repeat (3) cyc();
      en = 1'b1;
      wait_valid(c);
      check("en_gap_latency", c + 3, LAT + 3);
      check("en_gap_valid_after", c, LAT);
      en = 1'b0;
      repeat (5) cyc();
      check("hold_valid", key_valid, 1);
      target = n_acc + 1;
      key_ready = 1'b1;
      cyc();
      key_ready = 1'b0;
      check("hold_accept", n_acc, target);
      check("hold_accept_valid_low", key_valid, 0);
      en = 1'b1;
      wait_valid(c);
      rst = 1'b1;
      reseed(16'hACE1);
      cyc();
      check("mid_rst_key", key, 8'h00);
      check("mid_rst_valid", key_valid, 0);
      rst = 1'b0;
      wait_valid(c);
      check("restart_latency", c, LAT);
      check("restart_key", key, 8'hE4);
      key_ready = 1'b1;
      repeat (20) cyc();
      key_ready = 1'b0;
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/keystream_gen.md
# keystream_gen

Byte-wide keystream generator built on a 16-bit Fibonacci LFSR. It is the stage directly upstream of the 8-bit XOR combiner. Each accepted byte drives the combiner's B operand, and the plaintext or ciphertext byte drives A. It delivers bytes over a valid/ready handshake and can be reseeded at run time so both ends of a link share one sequence.

## Interface
- SEED_DEFAULT, 16'hACE1, LFSR state after reset; also substituted for an all-zero seed.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  generation enable; when low, the LFSR and step counter hold.
- seed_load  input  1  one-cycle strobe that loads `seed` into the LFSR.
- seed  input  16  new LFSR state, sampled when `seed_load` is high.
- key  output  8  current keystream byte, stable while `key_valid` is high.
- key_valid  output  1  `key` holds an unconsumed byte.
- key_ready  input  1  consumer accepts `key` when this and `key_valid` are both high at a rising edge.

## Operation
- LFSR polynomial is x^16+x^14+x^13+x^11+1.
- One step: f = s[15]^s[13]^s[12]^s[10], then s <= {s[14:0], f}.
- A byte is 8 steps. After the 8th step, key <= s[7:0], which equals the 8 feedback bits with the first one in the MSB.
- FSM states:
  - GEN: the step counter cnt (3 bits) advances once per cycle while `en` is high. On the step with cnt==7, load `key`, set `key_valid`, go to HOLD.
  - HOLD: `key` and `key_valid` are frozen regardless of `en`. On accept, clear `key_valid`, set cnt=0, go to GEN.
- Priority at each rising edge is `rst`, then `seed_load`, then accept/step.
- `seed_load` in any state:
  - s <= seed, or SEED_DEFAULT if seed==0.
  - cnt <= 0, `key_valid` <= 0, state <= GEN.
  - Any held or partial byte is discarded, including a byte being accepted in that same cycle.
- The state s never becomes all-zero.
- Raising `key_ready` while `key_valid` is low has no effect.

## Timing
- Reset values: s=SEED_DEFAULT, key=8'h00, key_valid=0, cnt=0, state=GEN.
- Serial mode latency: `key_valid` rises 8 enabled cycles after reset release, seed load or accept.
- Serial mode throughput is at most one byte per 9 cycles: 8 steps plus 1 accept cycle.
- A cycle with `en` low during GEN adds one cycle of latency. The step count is preserved, not restarted.
- Reset or `seed_load` in the middle of a byte drops `key_valid` at the next edge. No partial byte is ever presented.

## Configuration
- Macro `KEYSTREAM_PARALLEL_EN`.
- Defined:
  - All 8 steps are unrolled into one cycle, and cnt is removed.
  - `key_valid` rises 1 enabled cycle after reset release or seed load.
  - On accept with `en` high, the next byte is loaded in the same edge and `key_valid` stays high, giving one byte per cycle.
  - On accept with `en` low, `key_valid` drops.
- Undefined: the serial 8-cycle FSM described above.
- The byte sequence is identical in both modes.

## Structure
- Package `keystream_pkg` holds:
  - SEED_DEFAULT.
  - Tap positions {15,13,12,10}.
  - Steps per byte (8).
  - FSM state enum {GEN, HOLD}.
- Sub-module `lfsr16_step`: combinational single step, mapping s_in[15:0] to s_out[15:0] and f. It is instantiated once in serial mode and chained 8 times in parallel mode.

## Test plan
- Reset release with en=1, key_ready=0 -> key_valid rises after 8 cycles (1 in parallel mode); key=8'hE4; internal s=16'hE1E4.
- Accept the first byte (key_ready=1 for one cycle) -> the second byte equals the LFSR continuation from 16'hE1E4. Check 64 bytes against a reference model.
- seed_load with seed=16'h0000 -> behaves exactly as seed 16'hACE1; first key=8'hE4.
- seed_load at cnt=4 of a byte, and seed_load in the same cycle as an accept -> key_valid=0 next cycle; the next byte is the first byte for the new seed; the old byte never reappears.
- en toggled low for 3 cycles during GEN -> key_valid delayed by exactly 3 cycles; same key value. en low in HOLD -> key held, and accept still succeeds.
- rst asserted while key_valid=1 -> next edge gives key=8'h00, key_valid=0; the sequence restarts with 8'hE4.
